// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write scheduler.
//   FB_WIDTH / FB_HEIGHT : default frame buffer geometry (width is a power of two)
//   FB_ADDR_W            : linear address width for the default geometry
//   FB_PIX_W             : RGB444 pixel width
//   fb_state_t           : scheduler states
//   fb_req_t             : requester index into the 2-bit request/grant vectors
package fb_pkg;

  localparam int FB_WIDTH  = 512;
  localparam int FB_HEIGHT = 384;
  localparam int FB_ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT);
  localparam int FB_PIX_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } fb_state_t;

  typedef enum logic {
    REQ_BLK = 1'b0,
    REQ_HUD = 1'b1
  } fb_req_t;

endpackage

// File: rtl/fb_write_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
//   clk_in, rst_in : clock and synchronous active-high reset
//   en_in          : arbitration enable; no grants and no pointer movement when low
//   req_in[1:0]    : requests, indexed by fb_req_t
//   gnt_out[1:0]   : one-hot (or zero) combinational grant
// After reset the block renderer is favoured. The pointer only moves on
// contested cycles, so a lone requester never steals the other's next turn.
module rr_arbiter2
  import fb_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en_in,
  input  logic [1:0] req_in,
  output logic [1:0] gnt_out
);

  logic prio_hud_q;
  logic contested;

  assign contested = en_in && req_in[REQ_BLK] && req_in[REQ_HUD];

  always_comb begin
    gnt_out = '0;
    if (contested) begin
      if (prio_hud_q) gnt_out[REQ_HUD] = 1'b1;
      else            gnt_out[REQ_BLK] = 1'b1;
    end else if (en_in) begin
      gnt_out = req_in;
    end
  end

  // The winner of a contested cycle always loses the next one, so a toggle suffices.
  always_ff @(posedge clk_in) begin
    if (rst_in)         prio_hud_q <= 1'b0;
    else if (contested) prio_hud_q <= ~prio_hud_q;
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame buffer port-B write scheduler: optional clear sweep per frame, then
// round-robin arbitration between the block renderer and the HUD writer.
// Optional build macro: FB_HUD_TRANSPARENT_EN -- HUD pixels equal to zero are
// accepted but neither written nor counted as drops.
//   clk_in, rst_in             : clock, synchronous active-high reset
//   frame_start_in, clear_en_in: frame pulse and clear-sweep request
//   blk_* / hud_*              : valid/ready pixel streams with (x, y, colour)
//   fb_addr_out/data/we        : registered BRAM port-B write interface
//   busy_out                   : high on cycles carrying clear-sweep writes
//   clear_done_out             : one-cycle pulse after the last clear write
//   drop_count_out             : saturating count of out-of-range pixels
//
// state | meaning
// IDLE  | waiting for the first frame_start
// CLEAR | sweeping CLEAR_COLOR over every address, one per cycle
// RUN   | arbitrating pixel writers
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int                 WIDTH       = FB_WIDTH,
  parameter int                 HEIGHT      = FB_HEIGHT,
  parameter int                 PIX_W       = FB_PIX_W,
  parameter logic [PIX_W-1:0]   CLEAR_COLOR = '0
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              frame_start_in,
  input  logic                              clear_en_in,
  input  logic                              blk_valid_in,
  input  logic [10:0]                       blk_x_in,
  input  logic [9:0]                        blk_y_in,
  input  logic [PIX_W-1:0]                  blk_pixel_in,
  output logic                              blk_ready_out,
  input  logic                              hud_valid_in,
  input  logic [10:0]                       hud_x_in,
  input  logic [9:0]                        hud_y_in,
  input  logic [PIX_W-1:0]                  hud_pixel_in,
  output logic                              hud_ready_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   fb_addr_out,
  output logic [PIX_W-1:0]                  fb_data_out,
  output logic                              fb_we_out,
  output logic                              busy_out,
  output logic                              clear_done_out,
  output logic [15:0]                       drop_count_out
);

  localparam int                ADDR_W    = $clog2(WIDTH * HEIGHT);
  localparam int                XW        = $clog2(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              done_d, done_pend_q;
  logic              arb_en;
  logic [1:0]        req, gnt;

  logic              acc_valid, acc_hud;
  logic [10:0]       acc_x;
  logic [9:0]        acc_y;
  logic [PIX_W-1:0]  acc_pix;
  logic              in_range, transparent, do_write, do_drop;
  logic [ADDR_W-1:0] addr_calc;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    done_d    = 1'b0;
    arb_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          clr_cnt_d = '0;
          state_d   = clear_en_in ? CLEAR : RUN;
        end
      end
      CLEAR: begin
        // A new frame restarts the sweep regardless of clear_en_in.
        if (frame_start_in) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RUN: begin
        arb_en = 1'b1;
        if (frame_start_in && clear_en_in) begin
          clr_cnt_d = '0;
          state_d   = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign req = {hud_valid_in, blk_valid_in};

  rr_arbiter2 u_arb (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en_in   (arb_en),
    .req_in  (req),
    .gnt_out (gnt)
  );

  assign blk_ready_out = gnt[REQ_BLK];
  assign hud_ready_out = gnt[REQ_HUD];

  assign acc_valid = |gnt;
  assign acc_hud   = gnt[REQ_HUD];
  assign acc_x     = acc_hud ? hud_x_in     : blk_x_in;
  assign acc_y     = acc_hud ? hud_y_in     : blk_y_in;
  assign acc_pix   = acc_hud ? hud_pixel_in : blk_pixel_in;

  assign in_range  = (32'(acc_x) < WIDTH) && (32'(acc_y) < HEIGHT);
  assign addr_calc = (ADDR_W'(acc_y) << XW) + ADDR_W'(acc_x);

`ifdef FB_HUD_TRANSPARENT_EN
  assign transparent = acc_hud && (acc_pix == '0);
`else
  assign transparent = 1'b0;
`endif

  // Transparent pixels are neither written nor counted, even when out of range.
  assign do_write = acc_valid && in_range && !transparent;
  assign do_drop  = acc_valid && !in_range && !transparent;

  // All write-side outputs are registered so clear writes and pixel writes share
  // the same one-cycle latency; busy_out is aligned with the clear writes it covers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fb_we_out      <= 1'b0;
      fb_addr_out    <= '0;
      fb_data_out    <= '0;
      busy_out       <= 1'b0;
      done_pend_q    <= 1'b0;
      clear_done_out <= 1'b0;
      drop_count_out <= '0;
    end else begin
      busy_out       <= (state_q == CLEAR);
      done_pend_q    <= done_d;
      clear_done_out <= done_pend_q;
      if (state_q == CLEAR) begin
        fb_we_out   <= 1'b1;
        fb_addr_out <= clr_cnt_q;
        fb_data_out <= CLEAR_COLOR;
      end else if (do_write) begin
        fb_we_out   <= 1'b1;
        fb_addr_out <= addr_calc;
        fb_data_out <= acc_pix;
      end else begin
        fb_we_out   <= 1'b0;
      end
      if (do_drop && drop_count_out != 16'hFFFF)
        drop_count_out <= drop_count_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler with a 4x2 frame buffer. A behavioural model
// tracks frame mode, clear position, whose turn it is on contention and the
// drop count, and predicts readies and the registered write port every cycle.
module tb_fb_write_scheduler;

  localparam int W = 4;
  localparam int H = 2;
  localparam int AW = $clog2(W * H);

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_RUN   = 2;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          frame_start_in = 1'b0, clear_en_in = 1'b0;
  logic          blk_valid_in = 1'b0, hud_valid_in = 1'b0;
  logic [10:0]   blk_x_in = '0, hud_x_in = '0;
  logic [9:0]    blk_y_in = '0, hud_y_in = '0;
  logic [11:0]   blk_pixel_in = '0, hud_pixel_in = '0;
  logic          blk_ready_out, hud_ready_out;
  logic [AW-1:0] fb_addr_out;
  logic [11:0]   fb_data_out;
  logic          fb_we_out, busy_out, clear_done_out;
  logic [15:0]   drop_count_out;

  fb_write_scheduler #(.WIDTH(W), .HEIGHT(H), .PIX_W(12), .CLEAR_COLOR(12'h000)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .clear_en_in    (clear_en_in),
    .blk_valid_in   (blk_valid_in),
    .blk_x_in       (blk_x_in),
    .blk_y_in       (blk_y_in),
    .blk_pixel_in   (blk_pixel_in),
    .blk_ready_out  (blk_ready_out),
    .hud_valid_in   (hud_valid_in),
    .hud_x_in       (hud_x_in),
    .hud_y_in       (hud_y_in),
    .hud_pixel_in   (hud_pixel_in),
    .hud_ready_out  (hud_ready_out),
    .fb_addr_out    (fb_addr_out),
    .fb_data_out    (fb_data_out),
    .fb_we_out      (fb_we_out),
    .busy_out       (busy_out),
    .clear_done_out (clear_done_out),
    .drop_count_out (drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode = M_IDLE;
  int m_idx  = 0;
  bit m_hud_turn = 0;
  int m_drop = 0;
  bit m_pend = 0;
  bit e_we = 0, e_busy = 0, e_done = 0;
  int e_addr = 0, e_data = 0;
  bit e_rb = 0, e_rh = 0;

  int busy_cycles;
  int gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already applied. Check readies mid-cycle,
  // advance the model, then check the registered outputs after the edge.
  task automatic tick();
    int x, y, pix;
    bit transp;
    #2;
    e_rb = 0; e_rh = 0;
    if (!rst_in && m_mode == M_RUN) begin
      if (blk_valid_in && hud_valid_in) begin
        if (m_hud_turn) e_rh = 1; else e_rb = 1;
      end else begin
        e_rb = blk_valid_in;
        e_rh = hud_valid_in;
      end
    end
    if (!rst_in) begin
      chk("blk_ready", blk_ready_out, e_rb);
      chk("hud_ready", hud_ready_out, e_rh);
    end
    if (e_rb) gnt_log.push_back(0);
    if (e_rh) gnt_log.push_back(1);

    if (rst_in) begin
      m_mode = M_IDLE; m_idx = 0; m_hud_turn = 0; m_drop = 0; m_pend = 0;
      e_we = 0; e_addr = 0; e_data = 0; e_busy = 0; e_done = 0;
    end else begin
      e_done = m_pend;
      m_pend = 0;
      e_busy = (m_mode == M_CLEAR);
      e_we = 0;
      case (m_mode)
        M_IDLE: begin
          if (frame_start_in) begin
            m_mode = clear_en_in ? M_CLEAR : M_RUN;
            m_idx = 0;
          end
        end
        M_CLEAR: begin
          e_we = 1; e_addr = m_idx; e_data = 0;
          if (frame_start_in) m_idx = 0;
          else if (m_idx == W * H - 1) begin
            m_mode = M_RUN; m_idx = 0; m_pend = 1;
          end else m_idx++;
        end
        default: begin
          if (e_rb || e_rh) begin
            x   = e_rh ? int'(hud_x_in) : int'(blk_x_in);
            y   = e_rh ? int'(hud_y_in) : int'(blk_y_in);
            pix = e_rh ? int'(hud_pixel_in) : int'(blk_pixel_in);
            transp = 0;
`ifdef FB_HUD_TRANSPARENT_EN
            transp = e_rh && (pix == 0);
`endif
            if (!transp) begin
              if (x < W && y < H) begin
                e_we = 1; e_addr = y * W + x; e_data = pix;
              end else if (m_drop < 65535) m_drop++;
            end
          end
          if (blk_valid_in && hud_valid_in) m_hud_turn = !m_hud_turn;
          if (frame_start_in && clear_en_in) begin
            m_mode = M_CLEAR; m_idx = 0;
          end
        end
      endcase
    end

    @(posedge clk_in);
    #1;
    chk("fb_we", fb_we_out, e_we);
    chk("fb_addr", fb_addr_out, e_addr);
    chk("fb_data", fb_data_out, e_data);
    chk("busy", busy_out, e_busy);
    chk("clear_done", clear_done_out, e_done);
    chk("drop_count", drop_count_out, m_drop);
    if (busy_out) busy_cycles++;
  endtask

  task automatic idle_inputs();
    frame_start_in = 0; clear_en_in = 0;
    blk_valid_in = 0; hud_valid_in = 0;
  endtask

  task automatic set_blk(input int x, input int y, input int p);
    blk_valid_in = 1; blk_x_in = 11'(x); blk_y_in = 10'(y); blk_pixel_in = 12'(p);
  endtask

  task automatic set_hud(input int x, input int y, input int p);
    hud_valid_in = 1; hud_x_in = 11'(x); hud_y_in = 10'(y); hud_pixel_in = 12'(p);
  endtask

  initial begin
    @(posedge clk_in); #1;
    // Reset
    rst_in = 1; tick(); tick();
    rst_in = 0; tick();

    // Clear sweep from IDLE
    busy_cycles = 0;
    frame_start_in = 1; clear_en_in = 1; tick();
    idle_inputs();
    for (int i = 0; i < 11; i++) tick();
    chk("busy_cycles", busy_cycles, 8);

    // Single writer: (3,1) -> address 7
    set_blk(3, 1, 12'hF0A); tick();
    idle_inputs(); tick();

    // Contention: four cycles with both writers holding valid
    gnt_log.delete();
    set_blk(0, 0, 12'h111); set_hud(1, 0, 12'h222);
    for (int i = 0; i < 4; i++) tick();
    idle_inputs(); tick();
    chk("gnt_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("gnt_order", gnt_log[i], i % 2);

    // Out of range: x == W then y == H
    set_blk(4, 0, 12'h333); tick();
    idle_inputs(); set_hud(0, 2, 12'h444); tick();
    idle_inputs(); tick();
    chk("drop_two", drop_count_out, 2);

    // Transparency candidate: HUD black pixel at (1,1) -> address 5 when opaque
    set_hud(1, 1, 12'h000); tick();
    idle_inputs(); tick();

    // Saturation of the drop counter
    set_blk(7, 0, 12'h555);
    for (int i = 0; i < 65540; i++) tick();
    idle_inputs(); tick();
    chk("drop_sat", drop_count_out, 16'hFFFF);

    // Restart the sweep when the counter reaches 5
    frame_start_in = 1; clear_en_in = 1; tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    frame_start_in = 1; clear_en_in = 1; tick();
    idle_inputs(); tick();
    chk("restart_addr", fb_addr_out, 0);
    for (int i = 0; i < 10; i++) tick();

    // Reset in the middle of a sweep
    frame_start_in = 1; clear_en_in = 1; tick();
    idle_inputs(); tick(); tick(); tick();
    rst_in = 1; tick();
    rst_in = 0;
    chk("rst_we", fb_we_out, 0);
    set_blk(2, 0, 12'h777); tick();
    chk("idle_no_ready", 32'(blk_ready_out), 0);
    idle_inputs();
    frame_start_in = 1; clear_en_in = 0; tick();
    idle_inputs(); tick();

    // Randomized traffic with the hold-until-ready protocol
    for (int i = 0; i < 400; i++) begin
      bit keep_b, keep_h;
      keep_b = blk_valid_in && !e_rb;
      keep_h = hud_valid_in && !e_rh;
      rst_in = ($urandom_range(0, 199) == 0);
      frame_start_in = ($urandom_range(0, 39) == 0);
      clear_en_in = $urandom_range(0, 1);
      if (!keep_b) begin
        blk_valid_in = $urandom_range(0, 2) != 0;
        blk_x_in = 11'($urandom_range(0, 5));
        blk_y_in = 10'($urandom_range(0, 2));
        blk_pixel_in = 12'($urandom);
      end
      if (!keep_h) begin
        hud_valid_in = $urandom_range(0, 2) != 0;
        hud_x_in = 11'($urandom_range(0, 5));
        hud_y_in = 10'($urandom_range(0, 2));
        hud_pixel_in = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      end
      tick();
    end
    rst_in = 0; idle_inputs(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
